round_state_ctrl: RTL
=====================

Name: round_state_ctrl

Overview:
- Iterative round controller and state register for the uLBC-128 datapath; sits directly upstream of the SubByte stage.
- Holds the 128-bit cipher state and XORs the current round key into it. The result drives SubByte.
- Registers the returned round-function result (SubByte followed by the linear layer) once per cycle and counts rounds.
- Performs final key whitening and presents the ciphertext over a valid/ready handshake.

Parameters:
- NR, 32, number of full rounds.
- RW, 6, round counter width; must satisfy 2^RW > NR.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  plaintext offered.
- in_ready  output  1  block can accept plaintext.
- pt  input  128  plaintext, sampled on the in_valid && in_ready edge.
- rnd  output  RW  current round index; addresses the key schedule.
- rk  input  128  round key for index rnd; combinational and valid in the same cycle.
- sb_in  output  128  state ^ rk, fed to the SubByte s_in.
- lin_in  input  128  round-function result returned from SubByte plus the linear layer.
- out_valid  output  1  ct is valid.
- out_ready  input  1  consumer accepts ct.
- ct  output  128  ciphertext, registered.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- **Reset (asynchronous, rst_n=0):**
  - state register = 0, rnd = 0, ct = 0.
  - out_valid = 0, busy = 0, FSM = IDLE, in_ready = 1 (decoded from IDLE).
  - Reset takes effect immediately in any state; an in-flight block is discarded and no partial ct is ever flagged valid.
- **sb_in:** always state ^ rk (purely combinational), in every state.
- **FSM states:** IDLE, RUN, WHITEN, DONE.
- **IDLE:**
  - in_ready = 1.
  - On in_valid at a clock edge: state <= pt, rnd <= 0, go to RUN.
  - Otherwise hold all registers.
- **RUN:**
  - in_ready = 0.
  - Every edge: state <= lin_in, rnd <= rnd + 1.
  - When the edge takes rnd from NR-1 to NR, go to WHITEN.
  - Exactly NR state updates occur, using rk indices 0..NR-1.
- **WHITEN:**
  - rnd = NR.
  - Next edge: ct <= state ^ rk (the whitening key), out_valid <= 1, go to DONE.
  - state is not updated.
- **DONE:**
  - ct and out_valid are held stable until out_ready = 1 at an edge.
  - On that edge: out_valid <= 0, rnd <= 0, go to IDLE.
  - ct retains its value after the handshake.
- **Latency and throughput:**
  - out_valid rises NR+1 edges after the accept edge.
  - Minimum spacing between accepts is NR+3 cycles; there is no overlap of blocks.
  - in_valid asserted while busy is ignored; pt is not sampled.
- **Arithmetic:** rnd is an unsigned RW-bit counter and never exceeds NR, so it cannot wrap.
- **Simultaneous events:**
  - out_ready asserted outside DONE has no effect.
  - in_valid in the same cycle as the DONE handshake is not accepted; it is accepted on the following IDLE cycle.

Test Plan:
1. Assert rst_n=0 asynchronously between edges.
   - Required: state, ct and rnd are 0; out_valid=0, busy=0 and in_ready=1 immediately, without waiting for a clock edge.
2. Identity stub (lin_in = sb_in), rk = 0, pt = 128'h0123456789ABCDEF_FEDCBA9876543210.
   - Required: out_valid rises 33 edges after accept, and ct = pt.
3. Identity stub, rk constant 128'h1, pt = 0.
   - 32 rounds of XOR-1 leave the state at 0; whitening XORs in 1 more.
   - Required: ct = 128'h1, and rnd = 32 during WHITEN.
4. out_ready held low for 5 cycles in DONE, with in_valid pulsed during that time.
   - Required: ct and out_valid stay stable, in_ready = 0, and no new pt is captured.
   - After out_ready = 1: out_valid = 0 on the next edge, and the block is back in IDLE.
5. Assert rst_n=0 in RUN at rnd = 10.
   - Required: immediate return to IDLE with all outputs at their reset values.
   - A new block afterwards completes normally with correct ct.
6. in_valid held high with out_ready = 1.
   - Required: accepts occur every 35 cycles, and the second block's ct is independent of the first.
   - With a real SubByte plus linear layer attached, ct matches the golden software model for two random vectors.

Source files
------------

// File: rtl/round_state_ctrl.sv
// round_state_ctrl
//   Iterative round controller and 128-bit state register for the uLBC-128
//   datapath. The current round key is XORed into the state and sent to the
//   SubByte stage; the round-function result comes back on lin_in and is
//   registered once per cycle. After NR rounds the final whitening key is
//   applied and the ciphertext is offered over a valid/ready handshake.
//
// Ports
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready   plaintext handshake (in_ready high only in IDLE)
//   pt                  plaintext, captured on the accept edge
//   rnd                 current round index, addresses the key schedule
//   rk                  round key for rnd (combinational, same cycle)
//   sb_in               state ^ rk, drives SubByte
//   lin_in              SubByte + linear layer result
//   out_valid/out_ready ciphertext handshake
//   ct                  registered ciphertext
//   busy                high whenever the controller is not IDLE
module round_state_ctrl #(
    parameter int unsigned NR = 32,
    parameter int unsigned RW = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [127:0]  pt,
    output logic [RW-1:0] rnd,
    input  logic [127:0]  rk,
    output logic [127:0]  sb_in,
    input  logic [127:0]  lin_in,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [127:0]  ct,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        WHITEN,
        DONE
    } fsm_e;

    fsm_e          fsm_q, fsm_d;
    logic [127:0]  state_q, state_d;
    logic [127:0]  ct_q, ct_d;
    logic [RW-1:0] rnd_q, rnd_d;
    logic          out_valid_q, out_valid_d;

    // Key addition is purely combinational so the same path serves the
    // round keys in RUN and the whitening key in WHITEN.
    assign sb_in = state_q ^ rk;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q <= IDLE;
        end else begin
            fsm_q <= fsm_d;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= '0;
            ct_q        <= '0;
            rnd_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ct_q        <= ct_d;
            rnd_q       <= rnd_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Next-state logic
    always_comb begin
        fsm_d = fsm_q;
        unique case (fsm_q)
            IDLE:   if (in_valid) fsm_d = RUN;
            // The edge that takes rnd from NR-1 to NR performs the last round.
            RUN:    if (rnd_q == RW'(NR - 1)) fsm_d = WHITEN;
            WHITEN: fsm_d = DONE;
            DONE:   if (out_ready) fsm_d = IDLE;
            default: fsm_d = IDLE;
        endcase
    end

    // Datapath next values
    always_comb begin
        state_d     = state_q;
        ct_d        = ct_q;
        rnd_d       = rnd_q;
        out_valid_d = out_valid_q;
        unique case (fsm_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = pt;
                    rnd_d   = '0;
                end
            end
            RUN: begin
                state_d = lin_in;
                rnd_d   = rnd_q + RW'(1);
            end
            WHITEN: begin
                // rnd sits at NR here, so rk is the whitening key.
                ct_d        = sb_in;
                out_valid_d = 1'b1;
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    rnd_d       = '0;
                end
            end
            default: begin
                out_valid_d = 1'b0;
            end
        endcase
    end

    // Outputs
    always_comb begin
        in_ready  = (fsm_q == IDLE);
        busy      = (fsm_q != IDLE);
        rnd       = rnd_q;
        ct        = ct_q;
        out_valid = out_valid_q;
    end

endmodule
